// File: rtl/ahb_spi_flash_xip.sv
// AHB-Lite execute-in-place bridge to an SPI NOR flash (mode 0, single-bit reads).
// A miss fetches one LINE_WORDS-word line; reads that hit the line complete with zero wait states.
module ahb_spi_flash_xip #(
  parameter int         ADDR_WIDTH = 24,
  parameter int         LINE_WORDS = 4,
  parameter int         CLK_DIV    = 2,
  parameter logic [7:0] READ_CMD   = 8'h03
) (
  input  logic        hclk_i,
  input  logic        hreset_i,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic [31:0] hrdata_o,
  output logic        hready_o,
  output logic        hresp_o,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic        sck_o,
  output logic        ssn_o
);
  localparam int OFF_W   = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TAG_W   = ADDR_WIDTH - OFF_W;
  localparam int TX_BITS = 8 + ADDR_WIDTH;
  localparam int RX_BITS = 32 * LINE_WORDS;
  localparam int RXB_W   = $clog2(RX_BITS);
  localparam int CNT_W   = $clog2(TX_BITS + RX_BITS + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, ERR1, ERR2, SHIFT_TX, SHIFT_RX, RESP} state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    valid;
  logic [TAG_W-1:0]        tag_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TX_BITS-1:0]      tx_sr;
  logic [RX_BITS-1:0]      line_q;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [RXB_W-1:0]        rx_pos;
  logic                    accept, hit, tick, shifting, rise, fall, start_miss;
  logic                    unused;

  function automatic logic [31:0] line_word(input logic [RX_BITS-1:0] line,
                                            input logic [IDX_W-1:0] idx);
    return line[32*idx +: 32];
  endfunction

  generate
    if (LINE_WORDS > 1) begin : g_idx
      assign req_idx = haddr_i[OFF_W-1:2];
    end else begin : g_idx_single
      assign req_idx = '0;
    end
  endgenerate

  assign req_tag    = haddr_i[ADDR_WIDTH-1:OFF_W];
  assign accept     = hsel_i & htrans_i[1] & hready_i;
  assign hit        = valid && (tag_q == req_tag);
  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign shifting   = (state == SHIFT_TX) || (state == SHIFT_RX);
  assign rise       = shifting && tick && !sck_o;
  assign fall       = shifting && tick && sck_o;
  assign start_miss = ((state == IDLE) || (state == ERR2) || (state == RESP)) &&
                      accept && !hwrite_i && !hit;
  // Flash byte k lands little-endian in word k/4, bits arrive MSB first within each byte.
  assign rx_pos     = bit_cnt[RXB_W-1:0];
  assign unused     = ^{hsize_i, hwdata_i, haddr_i};

  always_ff @(posedge hclk_i) begin
    if (start_miss) begin
      tx_sr <= {READ_CMD, req_tag, OFF_W'(0)};
    end else if (fall && (state == SHIFT_TX)) begin
      tx_sr <= tx_sr << 1;
    end
    if (rise && (state == SHIFT_RX)) begin
      line_q[{rx_pos[RXB_W-1:3], ~rx_pos[2:0]}] <= miso_i;
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state    <= IDLE;
      hrdata_o <= '0;
      hready_o <= 1'b1;
      hresp_o  <= 1'b0;
      ssn_o    <= 1'b1;
      sck_o    <= 1'b0;
      mosi_o   <= 1'b0;
      valid    <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
    end else begin
      case (state)
        IDLE, ERR2, RESP: begin
          state    <= IDLE;
          hready_o <= 1'b1;
          hresp_o  <= 1'b0;
          ssn_o    <= 1'b1;
          if (accept) begin
            if (hwrite_i) begin
              state    <= ERR1;
              hready_o <= 1'b0;
              hresp_o  <= 1'b1;
            end else if (hit) begin
              hrdata_o <= line_word(line_q, req_idx);
            end else begin
              state    <= SHIFT_TX;
              hready_o <= 1'b0;
              ssn_o    <= 1'b0;
              sck_o    <= 1'b0;
              mosi_o   <= READ_CMD[7];
              div_cnt  <= '0;
              bit_cnt  <= '0;
              idx_q    <= req_idx;
              tag_q    <= req_tag;
              valid    <= 1'b0;
            end
          end
        end
        ERR1: begin
          state    <= ERR2;
          hready_o <= 1'b1;
          hresp_o  <= 1'b1;
        end
        SHIFT_TX, SHIFT_RX: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick && !sck_o) begin
            // The trailing low half after the last received bit ends the fill.
            if ((state == SHIFT_RX) && (bit_cnt == CNT_W'(RX_BITS))) begin
              state    <= RESP;
              ssn_o    <= 1'b1;
              hready_o <= 1'b1;
              hrdata_o <= line_word(line_q, idx_q);
              valid    <= 1'b1;
            end else begin
              sck_o <= 1'b1;
            end
          end else if (tick) begin
            sck_o <= 1'b0;
            if (state == SHIFT_TX) begin
              if (bit_cnt == CNT_W'(TX_BITS - 1)) begin
                state   <= SHIFT_RX;
                bit_cnt <= '0;
                mosi_o  <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                mosi_o  <= tx_sr[TX_BITS-2];
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_spi_flash_xip.sv
// Directed bench for ahb_spi_flash_xip: default instance plus a CLK_DIV=1, LINE_WORDS=1 instance,
// each with a behavioural SPI flash whose byte at address a is a[7:0].
module tb_ahb_spi_flash_xip;
  logic        hclk = 1'b0;
  logic        hreset = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  logic        hsel_a = 1'b0, hsel_b = 1'b0;
  logic [31:0] hrdata_a, hrdata_b;
  logic        hready_a, hready_b, hresp_a, hresp_b;
  logic        miso_a = 1'b0, miso_b = 1'b0;
  logic        mosi_a, mosi_b, sck_a, sck_b, ssn_a, ssn_b;

  int passed = 0;
  int total  = 0;

  always #5 hclk = ~hclk;

  ahb_spi_flash_xip dut_a (
    .hclk_i(hclk), .hreset_i(hreset), .hsel_i(hsel_a), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hready_i(hready_a),
    .hrdata_o(hrdata_a), .hready_o(hready_a), .hresp_o(hresp_a),
    .miso_i(miso_a), .mosi_o(mosi_a), .sck_o(sck_a), .ssn_o(ssn_a)
  );

  ahb_spi_flash_xip #(.ADDR_WIDTH(24), .LINE_WORDS(1), .CLK_DIV(1), .READ_CMD(8'h03)) dut_b (
    .hclk_i(hclk), .hreset_i(hreset), .hsel_i(hsel_b), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hready_i(hready_b),
    .hrdata_o(hrdata_b), .hready_o(hready_b), .hresp_o(hresp_b),
    .miso_i(miso_b), .mosi_o(mosi_b), .sck_o(sck_b), .ssn_o(ssn_b)
  );

  // Flash model A: capture command+address on SCK rise, drive data on SCK fall.
  int          cnt_a = 0, pulses_a = 0, falls_a = 0;
  logic [31:0] sr_a = '0, cap_a = '0;
  always @(posedge sck_a or posedge ssn_a) begin
    if (ssn_a) begin
      if (cnt_a != 0) begin
        pulses_a = cnt_a;
        cap_a    = sr_a;
      end
      cnt_a = 0;
    end else begin
      if (cnt_a < 32) sr_a = {sr_a[30:0], mosi_a};
      cnt_a++;
    end
  end
  always @(negedge sck_a) begin
    if (!ssn_a && cnt_a >= 32) begin
      logic [7:0] bv;
      bv     = 8'(sr_a[23:0] + 24'((cnt_a - 32) / 8));
      miso_a = bv[7 - ((cnt_a - 32) % 8)];
    end
  end
  always @(negedge ssn_a) falls_a++;

  int          cnt_b = 0, pulses_b = 0, falls_b = 0;
  logic [31:0] sr_b = '0, cap_b = '0;
  always @(posedge sck_b or posedge ssn_b) begin
    if (ssn_b) begin
      if (cnt_b != 0) begin
        pulses_b = cnt_b;
        cap_b    = sr_b;
      end
      cnt_b = 0;
    end else begin
      if (cnt_b < 32) sr_b = {sr_b[30:0], mosi_b};
      cnt_b++;
    end
  end
  always @(negedge sck_b) begin
    if (!ssn_b && cnt_b >= 32) begin
      logic [7:0] bv;
      bv     = 8'(sr_b[23:0] + 24'((cnt_b - 32) / 8));
      miso_b = bv[7 - ((cnt_b - 32) % 8)];
    end
  end
  always @(negedge ssn_b) falls_b++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic ahb_read(input int sel, input logic [31:0] addr,
                          output logic [31:0] data, output logic resp, output int waits);
    @(posedge hclk); #1;
    haddr = addr; htrans = 2'b10; hwrite = 1'b0;
    if (sel == 0) hsel_a = 1'b1; else hsel_b = 1'b1;
    @(posedge hclk); #1;
    htrans = 2'b00; hsel_a = 1'b0; hsel_b = 1'b0;
    waits = 0;
    @(negedge hclk);
    while (((sel == 0) ? hready_a : hready_b) == 1'b0 && waits < 2000) begin
      waits++;
      @(negedge hclk);
    end
    data = (sel == 0) ? hrdata_a : hrdata_b;
    resp = (sel == 0) ? hresp_a : hresp_b;
  endtask

  localparam int MISS_A = (8 + 24 + 128) * 2 * 2 + 2;
  localparam int MISS_B = (8 + 24 + 32) * 2 * 1 + 1;

  initial begin
    logic [31:0] data;
    logic        resp;
    int          waits;
    int          f0;

    #2 hreset = 1'b1;
    @(negedge hclk);
    chk("rst_hrdata", hrdata_a, 32'h0);
    chk("rst_hready", 32'(hready_a), 32'h1);
    chk("rst_hresp", 32'(hresp_a), 32'h0);
    chk("rst_ssn", 32'(ssn_a), 32'h1);
    chk("rst_sck", 32'(sck_a), 32'h0);
    chk("rst_mosi", 32'(mosi_a), 32'h0);
    #1 hreset = 1'b0;

    // Abort a fill partway through the receive phase.
    @(posedge hclk); #1;
    haddr = 32'h8; htrans = 2'b10; hsel_a = 1'b1;
    @(posedge hclk); #1;
    htrans = 2'b00; hsel_a = 1'b0;
    repeat (300) @(negedge hclk);
    chk("fill_ssn_low", 32'(ssn_a), 32'h0);
    chk("fill_hready_low", 32'(hready_a), 32'h0);
    #1 hreset = 1'b1;
    @(negedge hclk);
    chk("abort_ssn", 32'(ssn_a), 32'h1);
    chk("abort_sck", 32'(sck_a), 32'h0);
    chk("abort_hready", 32'(hready_a), 32'h1);
    #1 hreset = 1'b0;

    f0 = falls_a;
    ahb_read(0, 32'h8, data, resp, waits);
    chk("miss_waits", 32'(waits), 32'(MISS_A));
    chk("miss_data", data, 32'h0B0A0908);
    chk("miss_resp", 32'(resp), 32'h0);
    chk("miss_cmdaddr", cap_a, 32'h03000000);
    chk("miss_pulses", 32'(pulses_a), 32'd160);
    chk("miss_ssn_falls", 32'(falls_a - f0), 32'd1);

    // Pipelined hits 0x00 then 0x0C.
    f0 = falls_a;
    @(posedge hclk); #1;
    haddr = 32'h0; htrans = 2'b10; hsel_a = 1'b1;
    @(posedge hclk); #1;
    haddr = 32'hC;
    @(negedge hclk);
    chk("b2b0_hready", 32'(hready_a), 32'h1);
    chk("b2b0_data", hrdata_a, 32'h03020100);
    @(posedge hclk); #1;
    htrans = 2'b00; hsel_a = 1'b0;
    @(negedge hclk);
    chk("b2b1_hready", 32'(hready_a), 32'h1);
    chk("b2b1_data", hrdata_a, 32'h0F0E0D0C);
    chk("b2b_no_ssn", 32'(falls_a - f0), 32'd0);

    // Write gets a two-cycle ERROR and leaves the line intact.
    @(posedge hclk); #1;
    haddr = 32'h4; htrans = 2'b10; hwrite = 1'b1; hsel_a = 1'b1; hwdata = 32'hDEADBEEF;
    @(posedge hclk); #1;
    htrans = 2'b00; hwrite = 1'b0; hsel_a = 1'b0;
    @(negedge hclk);
    chk("err1_hready", 32'(hready_a), 32'h0);
    chk("err1_hresp", 32'(hresp_a), 32'h1);
    @(negedge hclk);
    chk("err2_hready", 32'(hready_a), 32'h1);
    chk("err2_hresp", 32'(hresp_a), 32'h1);
    @(negedge hclk);
    chk("post_err_hresp", 32'(hresp_a), 32'h0);
    ahb_read(0, 32'h4, data, resp, waits);
    chk("after_wr_waits", 32'(waits), 32'd0);
    chk("after_wr_data", data, 32'h07060504);

    // Address bits above ADDR_WIDTH alias.
    ahb_read(0, 32'h0100_0010, data, resp, waits);
    chk("alias_waits", 32'(waits), 32'(MISS_A));
    chk("alias_cmdaddr", cap_a, 32'h03000010);
    chk("alias_data", data, 32'h13121110);

    // Minimal configuration instance.
    f0 = falls_b;
    ahb_read(1, 32'h20, data, resp, waits);
    chk("b_waits", 32'(waits), 32'(MISS_B));
    chk("b_pulses", 32'(pulses_b), 32'd64);
    chk("b_cmdaddr", cap_b, 32'h03000020);
    chk("b_data", data, 32'h23222120);
    chk("b_resp", 32'(resp), 32'h0);

    f0 = falls_b;
    @(posedge hclk); #1;
    haddr = 32'h40; htrans = 2'b00; hsel_b = 1'b1;
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("b_idle_hready", 32'(hready_b), 32'h1);
    chk("b_idle_hresp", 32'(hresp_b), 32'h0);
    chk("b_idle_ssn", 32'(ssn_b), 32'h1);
    hsel_b = 1'b0;
    repeat (4) @(negedge hclk);
    chk("b_idle_no_spi", 32'(falls_b - f0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
